// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces press and release, and shifts each accepted digit into a 16-bit entry value.
// Latency: 2-cycle sync + rest of the row slot + DEBOUNCE + 1 cycles from press to key_valid; no backpressure.
module hex_keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 10000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  rows,
  input  logic [3:0]  cols,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [2:0]  digits
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_RELEASE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [3:0]    cols_m;
  logic [3:0]    cols_s;

  // Column priority: the lowest-index active-low column wins.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'h0;
      4'hD: return 4'hF;
      4'hE: return 4'hE;
      default: return 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SCAN;
      cnt       <= '0;
      row       <= 2'd0;
      col       <= 2'd0;
      rows      <= 4'b1110;
      cols_m    <= 4'hF;
      cols_s    <= 4'hF;
      value     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      digits    <= '0;
    end else begin
      cols_m    <= cols;
      cols_s    <= cols_m;
      key_valid <= 1'b0;

      case (state)
        ST_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (cols_s != 4'hF) begin
              col   <= low_col(cols_s);
              state <= ST_DEBOUNCE;
            end else begin
              rows <= {rows[2:0], rows[3]};
              row  <= row + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (cols_s[col]) begin
            cnt   <= '0;
            state <= ST_SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= ST_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_REPORT: begin
          key_valid <= 1'b1;
          key_code  <= key_map(row, col);
          value     <= {value[11:0], key_map(row, col)};
          digits    <= (digits == 3'd4) ? 3'd4 : digits + 3'd1;
          cnt       <= '0;
          state     <= ST_RELEASE;
        end

        ST_RELEASE: begin
          // Any low column, including other keys on this row, restarts the release window.
          if (cols_s != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            rows  <= {rows[2:0], rows[3]};
            row   <= row + 2'd1;
            state <= ST_SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_SCAN;
        end
      endcase

      // Placed after the FSM so a clear landing on the report cycle overrides the shift.
      if (clr) begin
        value  <= '0;
        digits <= '0;
      end
    end
  end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Input-side companion to the board's 4-digit seven-segment driver: scans a 4x4 hex keypad matrix, debounces presses and assembles a 16-bit, four-hex-digit entry value.
- The entry value feeds the display driver's 16-bit character input directly, and the CORDIC datapath loads operands from it.
- Each accepted key is reported as a one-cycle strobe with its hex code.
- The new digit shifts into the low nibble; older digits move left.

Parameters:
SCAN_DIV, 1000, clock cycles each row is driven before its columns are sampled (≥2)
DEBOUNCE, 10000, consecutive stable cycles required to accept a press or a release (≥2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rows  out  4  row drive, active-low, exactly one bit low at all times
cols  in  4  column sense, active-low (external pull-ups), asynchronous to clk
clr  in  1  synchronous clear of value and digit count
value  out  16  entry value, digit 0 in [3:0], newest digit
key_code  out  4  code of last accepted key
key_valid  out  1  one-cycle strobe on key acceptance
digits  out  3  number of digits entered, saturates at 4

Behaviour:
- Reset (async, any state): state=SCAN, rows=4'b1110 (row 0), value=0, key_code=0, key_valid=0, digits=0, counters=0.
- cols passes through a 2-flop synchroniser (cols_s). All decisions use cols_s only.
- Key map, row r / column c (c=0 at bit 0):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- SCAN state:
  - cnt runs 0..SCAN_DIV-1 with the current row driven.
  - At cnt=SCAN_DIV-1, sample cols_s.
  - If any bit is low: latch the lowest-index low column (column priority), keep the row, cnt=0, go to DEBOUNCE.
  - Else: advance row 0→1→2→3→0 (rows rotates left), cnt=0.
- DEBOUNCE state:
  - Row held.
  - While cols_s[latched col]=0, cnt increments.
  - At cnt=DEBOUNCE-1, go to REPORT.
  - If the latched column reads 1 first: return to SCAN on the same row with cnt=0; no report.
- REPORT state (exactly one cycle):
  - key_valid=1 and key_code=mapped code.
  - value <= {value[11:0], code}; digits <= min(digits+1, 4).
  - Next state RELEASE, cnt=0.
- RELEASE state:
  - Row held.
  - While cols_s==4'b1111, cnt increments; any low bit resets cnt to 0.
  - At cnt=DEBOUNCE-1, go to SCAN on the next row, cnt=0.
  - A held key therefore produces exactly one report; there is no auto-repeat.
- Multiple keys:
  - Same row: lowest column wins.
  - Keys in other rows are not seen until RELEASE completes.
- clr:
  - Synchronous, any state: value=0, digits=0. The FSM is unaffected.
  - clr coincident with REPORT: clr wins for value/digits (both 0); key_valid and key_code still update.
- After 4 digits, further keys keep shifting and the oldest digit is dropped; digits stays 4.
- Minimum press-to-strobe latency from a stable cols edge at the sampled row: 2 (sync) + remaining row slot + DEBOUNCE + 1 cycles.
- Outputs are all registered.
- Reset asserted mid-DEBOUNCE or mid-RELEASE discards the pending key. After reset, scanning restarts at row 0.

Test Plan:
(Parameters for the bench: SCAN_DIV=4, DEBOUNCE=8.)
1. Reset, no keys → rows cycles 1110,1101,1011,0111 every 4 cycles. value=0, key_valid never asserts.
2. Hold r1/c2 low for 40 cycles then release → exactly one key_valid pulse, key_code=6, value=16'h0006, digits=1. Scanning resumes at row 2 ≥8 cycles after release.
3. Press sequence 1,2,3,A,0 (each held 40 cycles, 40-cycle gaps) → value ends 16'h23A0, digits=4, five strobes.
4. Bounce: toggle r0/c0 low/high every 3 cycles for 30 cycles, then release → no strobe. Then hold steady → one strobe, key_code=1.
5. r3/c1 and r3/c3 pressed together → key_code=F only. A second strobe occurs only after both are released ≥8 cycles and re-pressed.
6. clr asserted on the REPORT cycle of key 5 with value=16'h1234 → value=0, digits=0, key_valid=1, key_code=5. Reset asserted mid-DEBOUNCE → no strobe, rows=1110.
